// File: rtl/router_fsm_np.sv
// Parametrised router control FSM: header decode, load/stall/parity sequencing,
// invalid-address drop, bounded wait-for-empty timeout and a saturating drop counter.
module router_fsm_np #(
  parameter int NUM_PORTS    = 3,
  parameter int ADDR_W       = 3,
  parameter int WAIT_TIMEOUT = 64,
  parameter int DROP_CNT_W   = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  packet_valid,
  input  logic [ADDR_W-1:0]     data_in,
  input  logic [NUM_PORTS-1:0]  fifo_empty,
  input  logic                  fifo_full,
  input  logic [NUM_PORTS-1:0]  soft_reset,
  input  logic                  parity_done,
  input  logic                  low_packet_valid,
  output logic [NUM_PORTS-1:0]  dest_sel,
  output logic                  busy,
  output logic                  detect_add,
  output logic                  lfd_state,
  output logic                  ld_state,
  output logic                  laf_state,
  output logic                  full_state,
  output logic                  write_enb_reg,
  output logic                  rst_int_reg,
  output logic                  drop_state,
  output logic                  timeout_pulse,
  output logic [DROP_CNT_W-1:0] drop_count
);

  // A zero timeout still needs a legal one-bit counter.
  localparam int WCW = (WAIT_TIMEOUT > 0) ? $clog2(WAIT_TIMEOUT + 1) : 1;

  typedef enum logic [3:0] {
    DECODE,
    WAIT_EMPTY,
    LOAD_FIRST,
    LOAD_DATA,
    FIFO_FULL,
    LOAD_AFTER_FULL,
    LOAD_PARITY,
    CHECK_PARITY,
    DROP
  } state_t;

  state_t                state, next_state;
  logic [ADDR_W-1:0]     dest_addr;
  logic                  dest_vld;
  logic [WCW-1:0]        wait_cnt;
  logic                  latch_hdr, clr_vld;

  logic [NUM_PORTS-1:0]  hdr_onehot, dest_onehot;
  logic                  hdr_valid, hdr_empty, sel_empty, sel_soft, timeout_hit;

  assign hdr_onehot  = NUM_PORTS'(1) << data_in;
  assign dest_onehot = NUM_PORTS'(1) << dest_addr;
  assign hdr_valid   = data_in < ADDR_W'(NUM_PORTS);
  assign hdr_empty   = |(fifo_empty & hdr_onehot);
  assign sel_empty   = |(fifo_empty & dest_onehot);
  assign sel_soft    = dest_vld && |(soft_reset & dest_onehot);
  assign timeout_hit = (WAIT_TIMEOUT != 0) && (wait_cnt == WCW'(WAIT_TIMEOUT - 1));
  assign dest_sel    = dest_vld ? dest_onehot : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= DECODE;
      dest_addr  <= '0;
      dest_vld   <= 1'b0;
      wait_cnt   <= '0;
      drop_count <= '0;
    end else begin
      state <= next_state;
      if (latch_hdr) begin
        dest_addr <= data_in;
        dest_vld  <= 1'b1;
      end else if (clr_vld) begin
        dest_vld  <= 1'b0;
      end
      wait_cnt <= (state == WAIT_EMPTY) ? wait_cnt + WCW'(1) : '0;
      if (next_state == DROP && state != DROP && drop_count != '1)
        drop_count <= drop_count + 1'b1;
    end
  end

  // Soft reset of the selected port overrides every other transition outside DECODE/DROP.
  always_comb begin
    next_state    = state;
    busy          = 1'b0;
    detect_add    = 1'b0;
    lfd_state     = 1'b0;
    ld_state      = 1'b0;
    laf_state     = 1'b0;
    full_state    = 1'b0;
    write_enb_reg = 1'b0;
    rst_int_reg   = 1'b0;
    drop_state    = 1'b0;
    timeout_pulse = 1'b0;
    latch_hdr     = 1'b0;
    clr_vld       = 1'b0;

    if (state != DECODE && state != DROP && sel_soft) begin
      next_state = DECODE;
      clr_vld    = 1'b1;
    end else begin
      case (state)
        DECODE: begin
          if (packet_valid) begin
            if (hdr_valid) begin
              detect_add = 1'b1;
              latch_hdr  = 1'b1;
              next_state = hdr_empty ? LOAD_FIRST : WAIT_EMPTY;
            end else begin
              clr_vld    = 1'b1;
              next_state = DROP;
            end
          end
        end
        WAIT_EMPTY: begin
          busy = 1'b1;
          if (sel_empty) begin
            next_state = LOAD_FIRST;
          end else if (timeout_hit) begin
            timeout_pulse = 1'b1;
            next_state    = DROP;
          end
        end
        LOAD_FIRST: begin
          lfd_state  = 1'b1;
          busy       = 1'b1;
          next_state = LOAD_DATA;
        end
        LOAD_DATA: begin
          ld_state      = 1'b1;
          write_enb_reg = 1'b1;
          if (fifo_full)          next_state = FIFO_FULL;
          else if (!packet_valid) next_state = LOAD_PARITY;
        end
        FIFO_FULL: begin
          full_state = 1'b1;
          busy       = 1'b1;
          if (!fifo_full) next_state = LOAD_AFTER_FULL;
        end
        LOAD_AFTER_FULL: begin
          laf_state     = 1'b1;
          busy          = 1'b1;
          write_enb_reg = 1'b1;
          if (parity_done)           next_state = DECODE;
          else if (low_packet_valid) next_state = LOAD_PARITY;
          else                       next_state = LOAD_DATA;
        end
        LOAD_PARITY: begin
          busy          = 1'b1;
          write_enb_reg = 1'b1;
          next_state    = CHECK_PARITY;
        end
        CHECK_PARITY: begin
          busy        = 1'b1;
          rst_int_reg = 1'b1;
          next_state  = fifo_full ? FIFO_FULL : DECODE;
        end
        DROP: begin
          drop_state = 1'b1;
          if (!packet_valid) next_state = DECODE;
        end
        default: next_state = DECODE;
      endcase
    end
  end

endmodule

// File: tb/tb_router_fsm_np.sv
// Directed, table-driven bench for router_fsm_np (3 ports, timeout 4, 3-bit drop counter).
module tb_router_fsm_np;

  localparam int NP = 3;
  localparam int AW = 3;
  localparam int WT = 4;
  localparam int DW = 3;

  localparam logic [9:0] BUSY = 10'h200, DET  = 10'h100, LFD  = 10'h080, LD  = 10'h040,
                         LAF  = 10'h020, FULL = 10'h010, WEN  = 10'h008, RSTI = 10'h004,
                         DRP  = 10'h002, TMO  = 10'h001, NONE = 10'h000;

  typedef struct {
    logic          pv;
    logic [AW-1:0] d;
    logic [NP-1:0] fe;
    logic          ff;
    logic [NP-1:0] sr;
    logic          pd;
    logic          lpv;
    logic [NP-1:0] exp_sel;
    logic [9:0]    exp_strb;
    logic [DW-1:0] exp_dc;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic packet_valid = 1'b0;
  logic [AW-1:0] data_in = '0;
  logic [NP-1:0] fifo_empty = '0;
  logic fifo_full = 1'b0;
  logic [NP-1:0] soft_reset = '0;
  logic parity_done = 1'b0;
  logic low_packet_valid = 1'b0;
  logic [NP-1:0] dest_sel;
  logic busy, detect_add, lfd_state, ld_state, laf_state, full_state;
  logic write_enb_reg, rst_int_reg, drop_state, timeout_pulse;
  logic [DW-1:0] drop_count;

  int checks = 0;
  int failures = 0;
  vec_t vecs[$];

  router_fsm_np #(.NUM_PORTS(NP), .ADDR_W(AW), .WAIT_TIMEOUT(WT), .DROP_CNT_W(DW)) dut (
    .clock(clock), .reset(reset), .packet_valid(packet_valid), .data_in(data_in),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full), .soft_reset(soft_reset),
    .parity_done(parity_done), .low_packet_valid(low_packet_valid), .dest_sel(dest_sel),
    .busy(busy), .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
    .laf_state(laf_state), .full_state(full_state), .write_enb_reg(write_enb_reg),
    .rst_int_reg(rst_int_reg), .drop_state(drop_state), .timeout_pulse(timeout_pulse),
    .drop_count(drop_count)
  );

  always #5 clock = ~clock;

  function automatic vec_t mkv(input logic pv, input logic [AW-1:0] d, input logic [NP-1:0] fe,
                               input logic ff, input logic [NP-1:0] sr, input logic pd,
                               input logic lpv, input logic [NP-1:0] sel, input logic [9:0] st,
                               input logic [DW-1:0] dc);
    vec_t v;
    v.pv = pv; v.d = d; v.fe = fe; v.ff = ff; v.sr = sr; v.pd = pd; v.lpv = lpv;
    v.exp_sel = sel; v.exp_strb = st; v.exp_dc = dc;
    return v;
  endfunction

  // Drive inputs after the falling edge and let the combinational strobes settle.
  task automatic applyStimulus(input vec_t v);
    @(negedge clock);
    packet_valid     = v.pv;
    data_in          = v.d;
    fifo_empty       = v.fe;
    fifo_full        = v.ff;
    soft_reset       = v.sr;
    parity_done      = v.pd;
    low_packet_valid = v.lpv;
    #1;
  endtask

  task automatic checkOutput(input string name, input vec_t v);
    logic [9:0] strb;
    strb = {busy, detect_add, lfd_state, ld_state, laf_state, full_state,
            write_enb_reg, rst_int_reg, drop_state, timeout_pulse};
    checks++;
    if (strb !== v.exp_strb) begin
      failures++;
      $display("[TB] FAIL %s strobes: got %b want %b", name, strb, v.exp_strb);
    end
    checks++;
    if (dest_sel !== v.exp_sel) begin
      failures++;
      $display("[TB] FAIL %s dest_sel: got %b want %b", name, dest_sel, v.exp_sel);
    end
    checks++;
    if (drop_count !== v.exp_dc) begin
      failures++;
      $display("[TB] FAIL %s drop_count: got %0d want %0d", name, drop_count, v.exp_dc);
    end
  endtask

  initial begin
    vec_t v;
    logic [DW-1:0] dc_model;

    // reset state
    vecs.push_back(mkv(0, 0, 3'b000, 0, 0, 0, 0, 3'b000, NONE, 0));
    // normal packet to port 2, five body bytes
    vecs.push_back(mkv(1, 2, 3'b111, 0, 0, 0, 0, 3'b000, DET, 0));
    vecs.push_back(mkv(1, 2, 3'b111, 0, 0, 0, 0, 3'b100, LFD | BUSY, 0));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mkv(1, 2, 3'b111, 0, 0, 0, 0, 3'b100, LD | WEN, 0));
    vecs.push_back(mkv(0, 2, 3'b111, 0, 0, 0, 0, 3'b100, LD | WEN, 0));
    vecs.push_back(mkv(0, 2, 3'b111, 0, 0, 0, 0, 3'b100, BUSY | WEN, 0));
    vecs.push_back(mkv(0, 2, 3'b111, 0, 0, 0, 0, 3'b100, BUSY | RSTI, 0));
    vecs.push_back(mkv(0, 2, 3'b111, 0, 0, 0, 0, 3'b100, NONE, 0));
    // invalid address 3, packet_valid held through the drop
    vecs.push_back(mkv(1, 3, 3'b111, 0, 0, 0, 0, 3'b100, NONE, 0));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mkv(1, 3, 3'b111, 0, 0, 0, 0, 3'b000, DRP, 1));
    vecs.push_back(mkv(0, 3, 3'b111, 0, 0, 0, 0, 3'b000, DRP, 1));
    vecs.push_back(mkv(0, 3, 3'b111, 0, 0, 0, 0, 3'b000, NONE, 1));
    // port 1 never empties: timeout in the fourth wait cycle
    vecs.push_back(mkv(1, 1, 3'b101, 0, 0, 0, 0, 3'b000, DET, 1));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mkv(1, 1, 3'b101, 0, 0, 0, 0, 3'b010, BUSY, 1));
    vecs.push_back(mkv(1, 1, 3'b101, 0, 0, 0, 0, 3'b010, BUSY | TMO, 1));
    vecs.push_back(mkv(0, 1, 3'b101, 0, 0, 0, 0, 3'b010, DRP, 2));
    // port 0 empties exactly on the timeout cycle, then full stall and soft resets
    vecs.push_back(mkv(1, 0, 3'b110, 0, 0, 0, 0, 3'b010, DET, 2));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mkv(1, 0, 3'b110, 0, 0, 0, 0, 3'b001, BUSY, 2));
    vecs.push_back(mkv(1, 0, 3'b111, 0, 0, 0, 0, 3'b001, BUSY, 2));
    vecs.push_back(mkv(1, 0, 3'b111, 0, 0, 0, 0, 3'b001, LFD | BUSY, 2));
    vecs.push_back(mkv(1, 0, 3'b111, 0, 0, 0, 0, 3'b001, LD | WEN, 2));
    vecs.push_back(mkv(1, 0, 3'b111, 1, 0, 0, 0, 3'b001, LD | WEN, 2));
    vecs.push_back(mkv(1, 0, 3'b111, 1, 0, 0, 0, 3'b001, FULL | BUSY, 2));
    vecs.push_back(mkv(1, 0, 3'b111, 1, 0, 0, 0, 3'b001, FULL | BUSY, 2));
    vecs.push_back(mkv(1, 0, 3'b111, 0, 0, 0, 0, 3'b001, FULL | BUSY, 2));
    vecs.push_back(mkv(1, 0, 3'b111, 0, 0, 0, 0, 3'b001, LAF | BUSY | WEN, 2));
    vecs.push_back(mkv(1, 0, 3'b111, 0, 3'b010, 0, 0, 3'b001, LD | WEN, 2));
    vecs.push_back(mkv(1, 0, 3'b111, 1, 3'b001, 0, 0, 3'b001, NONE, 2));
    vecs.push_back(mkv(0, 0, 3'b111, 0, 0, 0, 0, 3'b000, NONE, 2));
    // short packet: parity check sees full, then parity_done ends the stall path
    vecs.push_back(mkv(1, 2, 3'b111, 0, 0, 0, 0, 3'b000, DET, 2));
    vecs.push_back(mkv(1, 2, 3'b111, 0, 0, 0, 0, 3'b100, LFD | BUSY, 2));
    vecs.push_back(mkv(0, 2, 3'b111, 0, 0, 0, 0, 3'b100, LD | WEN, 2));
    vecs.push_back(mkv(0, 2, 3'b111, 0, 0, 0, 0, 3'b100, BUSY | WEN, 2));
    vecs.push_back(mkv(0, 2, 3'b111, 1, 0, 0, 0, 3'b100, BUSY | RSTI, 2));
    vecs.push_back(mkv(0, 2, 3'b111, 0, 0, 0, 0, 3'b100, FULL | BUSY, 2));
    vecs.push_back(mkv(0, 2, 3'b111, 0, 0, 1, 0, 3'b100, LAF | BUSY | WEN, 2));
    vecs.push_back(mkv(0, 2, 3'b111, 0, 0, 0, 0, 3'b100, NONE, 2));

    repeat (2) @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d", i), vecs[i]);
    end

    // repeated invalid headers drive the drop counter into saturation
    dc_model = 3'd2;
    for (int i = 0; i < (1 << DW) + 2; i++) begin
      v = mkv(1, 5, 3'b111, 0, 0, 0, 0, (i == 0) ? 3'b100 : 3'b000, NONE, dc_model);
      applyStimulus(v);
      checkOutput($sformatf("sat_hdr%0d", i), v);
      dc_model = (dc_model == '1) ? dc_model : dc_model + 1'b1;
      v = mkv(0, 5, 3'b111, 0, 0, 0, 0, 3'b000, DRP, dc_model);
      applyStimulus(v);
      checkOutput($sformatf("sat_drop%0d", i), v);
    end

    // reset in the middle of a packet
    v = mkv(1, 0, 3'b111, 0, 0, 0, 0, 3'b000, DET, 3'd7);
    applyStimulus(v);
    checkOutput("mid_hdr", v);
    v = mkv(1, 0, 3'b111, 0, 0, 0, 0, 3'b001, LFD | BUSY, 3'd7);
    applyStimulus(v);
    checkOutput("mid_lfd", v);
    reset = 1'b1;
    v = mkv(0, 0, 3'b000, 0, 0, 0, 0, 3'b000, NONE, 3'd0);
    applyStimulus(v);
    checkOutput("mid_reset", v);
    reset = 1'b0;
    applyStimulus(v);
    checkOutput("post_reset", v);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
